obi_stall_injector: RTL

Testbench-side OBI timing perturber that sits between one core memory port (instruction or data) and the `mm_ram` port it drives in the core testbench wrapper, one instance per port. It withholds grants for pseudo-random cycle counts and buffers memory responses in a FIFO, releasing each one after a pseudo-random delay. This stresses the core's fetch and LSU handshakes without modifying the memory model. With `stall_en_i` low it adds a fixed one-cycle response latency and no grant stalls.

---
 rtl/obi_stall_injector.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/obi_stall_injector.sv
// obi_stall_injector: OBI timing perturber placed between one core memory
// port and its mm_ram port. Grants are withheld for pseudo-random cycle
// counts and memory responses are buffered in a FIFO, each released after
// a pseudo-random delay, in order. With stall_en_i low it only adds a
// fixed one-cycle response latency.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   stall_en_i           enables random grant/response stalls
//   req_i, gnt_o         core request / grant
//   addr_i, we_i, be_i,
//   wdata_i              core request fields
//   rvalid_o, rdata_o    response to core (rdata_o is 0 when not valid)
//   mem_req_o, mem_gnt_i memory request / grant
//   mem_addr_o, mem_we_o,
//   mem_be_o, mem_wdata_o combinational copies of the core fields
//   mem_rvalid_i,
//   mem_rdata_i          memory response
//   err_o                sticky protocol error
module obi_stall_injector #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned MAX_GNT_STALL    = 3,
    parameter int unsigned MAX_RVALID_STALL = 3,
    parameter logic [31:0] LFSR_SEED        = 32'hACE1_2345
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_en_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [31:0]      LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FWD
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            gcnt_q, gcnt_d;
    logic [7:0]            rcnt_q;
    logic [31:0]           lfsr_q;
    logic [CNT_W-1:0]      outst_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  err_q;

    logic [7:0] g_rand;
    logic [7:0] r_rand;
    logic       fwd;
    logic       outst_ok;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push;
    logic       spurious;
    logic       err_set;
    logic       rcnt_load;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Stall amounts are sampled only when a counter is loaded.
    assign g_rand = stall_en_i
                  ? 8'(32'(lfsr_q[7:0]) % (MAX_GNT_STALL + 1)) : 8'd0;
    assign r_rand = stall_en_i
                  ? 8'(32'(lfsr_q[15:8]) % (MAX_RVALID_STALL + 1)) : 8'd0;

    assign mem_addr_o  = addr_i;
    assign mem_we_o    = we_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;

    assign outst_ok = outst_q < DEPTH;

    // fwd is high whenever the FSM is, or enters, FWD in this cycle; the
    // reset gate keeps the combinational grant path quiet during reset.
    assign mem_req_o = fwd && outst_ok && rst_ni;
    assign gnt_o     = mem_req_o && mem_gnt_i;

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        fwd     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    gcnt_d = g_rand;
                    if (g_rand == 8'd0) begin
                        fwd     = 1'b1;
                        state_d = S_FWD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                end else if (gcnt_q <= 8'd1) begin
                    // last stall cycle: counter hits zero and forwards now
                    gcnt_d  = 8'd0;
                    fwd     = 1'b1;
                    state_d = S_FWD;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            S_FWD: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                end else begin
                    fwd = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (fwd && outst_ok && mem_gnt_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            gcnt_q  <= 8'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            lfsr_q  <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
        end
    end

    assign fifo_empty = count_q == '0;
    assign fifo_full  = count_q == DEPTH;
    assign rvalid_o   = !fifo_empty && (rcnt_q == 8'd0);
    assign rdata_o    = rvalid_o ? mem_q[rd_ptr_q] : '0;
    assign pop        = rvalid_o;

    // A response with no granted transaction waiting for it is discarded,
    // so the outstanding count can never fall below the FIFO occupancy.
    assign spurious = mem_rvalid_i && (outst_q == count_q);
    assign push     = mem_rvalid_i && !spurious && (!fifo_full || pop);
    assign err_set  = spurious || (mem_rvalid_i && fifo_full && !pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // A fresh delay applies to each entry as it becomes the head.
    assign rcnt_load = (push && fifo_empty) || (pop && (count_d != '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rcnt_q   <= 8'd0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (rcnt_load) begin
                rcnt_q <= r_rand;
            end else if (!fifo_empty && (rcnt_q != 8'd0)) begin
                rcnt_q <= rcnt_q - 8'd1;
            end
            if (gnt_o && !pop) begin
                outst_q <= outst_q + 1'b1;
            end else if (!gnt_o && pop && (outst_q != '0)) begin
                outst_q <= outst_q - 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    assign err_o = err_q;

endmodule
